// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state type and opcode classification
// for the multi-cycle ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_NAND = 4'h4;
    localparam logic [3:0] OP_NOR  = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_XNOR = 4'h7;
    localparam logic [3:0] OP_ID   = 4'h8;
    localparam logic [3:0] OP_NOT  = 4'h9;
    localparam logic [3:0] OP_LRS  = 4'hA;
    localparam logic [3:0] OP_ARS  = 4'hB;
    localparam logic [3:0] OP_RR   = 4'hC;
    localparam logic [3:0] OP_LLS  = 4'hD;
    localparam logic [3:0] OP_ALS  = 4'hE;
    localparam logic [3:0] OP_RL   = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op >= OP_LRS);
    endfunction

endpackage

// File: rtl/alu_comb_unit.sv
// Combinational datapath: single-cycle ops with signed overflow, plus the
// 1-bit step applied to the work register during iterative shifts/rotates.
module alu_comb_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       step_op_i,
    input  logic [WIDTH-1:0] work_i,
    output logic [WIDTH-1:0] res_o,
    output logic             v_o,
    output logic [WIDTH-1:0] step_o
);

    localparam int MSB = WIDTH - 1;

    // Single-cycle result and overflow; shift ops pass A through (amount-0 case)
    always_comb begin
        res_o = '0;
        v_o   = 1'b0;
        case (op_i)
            OP_ADD: begin
                res_o = a_i + b_i;
                v_o   = (a_i[MSB] == b_i[MSB]) && (res_o[MSB] != a_i[MSB]);
            end
            OP_SUB: begin
                res_o = a_i - b_i;
                v_o   = (a_i[MSB] != b_i[MSB]) && (res_o[MSB] != a_i[MSB]);
            end
            OP_AND:  res_o = a_i & b_i;
            OP_OR:   res_o = a_i | b_i;
            OP_NAND: res_o = ~(a_i & b_i);
            OP_NOR:  res_o = ~(a_i | b_i);
            OP_XOR:  res_o = a_i ^ b_i;
            OP_XNOR: res_o = ~(a_i ^ b_i);
            OP_ID:   res_o = a_i;
            OP_NOT:  res_o = ~a_i;
            default: res_o = a_i;
        endcase
    end

    // One-bit shift/rotate step on the work register
    always_comb begin
        step_o = work_i;
        case (step_op_i)
            OP_LRS:          step_o = {1'b0, work_i[MSB:1]};
            OP_ARS:          step_o = {work_i[MSB], work_i[MSB:1]};
            OP_RR:           step_o = {work_i[0], work_i[MSB:1]};
            OP_LLS, OP_ALS:  step_o = {work_i[MSB-1:0], 1'b0};
            OP_RL:           step_o = {work_i[MSB-1:0], work_i[MSB]};
            default:         step_o = work_i;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshakes: single-cycle ops finish in one
// cycle, shifts/rotates iterate one bit per cycle; result and Z/N/V registered.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int SHIFT_BY_B = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_c,
    output logic             out_v,
    output logic             out_z,
    output logic             out_n
);

    localparam int SHAMT_W = $clog2(WIDTH);

    state_t             state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   c_q, c_d;
    logic               v_q, v_d, z_q, z_d, n_q, n_d;

    logic [SHAMT_W-1:0] amt_s;
    logic [WIDTH-1:0]   res_s, step_s;
    logic               ovf_s;

    assign amt_s = (SHIFT_BY_B != 0) ? in_b[SHAMT_W-1:0] : SHAMT_W'(1);

    alu_comb_unit #(.WIDTH(WIDTH)) u_comb (
        .op_i      (in_op),
        .a_i       (in_a),
        .b_i       (in_b),
        .step_op_i (op_q),
        .work_i    (work_q),
        .res_o     (res_s),
        .v_o       (ovf_s),
        .step_o    (step_s)
    );

    // Next-state, iteration and result-capture logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        op_d    = op_q;
        c_d     = c_q;
        v_d     = v_q;
        z_d     = z_q;
        n_d     = n_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d = in_op;
                    if (is_shift(in_op) && (amt_s != '0)) begin
                        work_d  = in_a;
                        cnt_d   = amt_s;
                        state_d = SHIFT;
                    end else begin
                        c_d     = res_s;
                        v_d     = ovf_s;
                        z_d     = (res_s == '0);
                        n_d     = res_s[WIDTH-1];
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                work_d = step_s;
                cnt_d  = cnt_q - SHAMT_W'(1);
                // Final step lands straight in the output register
                if (cnt_q == SHAMT_W'(1)) begin
                    c_d     = step_s;
                    v_d     = 1'b0;
                    z_d     = (step_s == '0);
                    n_d     = step_s[WIDTH-1];
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            op_q    <= OP_ADD;
            c_q     <= '0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            op_q    <= op_d;
            c_q     <= c_d;
            v_q     <= v_d;
            z_q     <= z_d;
            n_q     <= n_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_c     = c_q;
    assign out_v     = v_q;
    assign out_z     = z_q;
    assign out_n     = n_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized self-checking bench for alu_seq against an arithmetic reference
// model, plus directed corner cases (overflow, amount 0, backpressure, abort).
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_c;
    logic        out_v;
    logic        out_z;
    logic        out_n;

    int n_cmp = 0;
    int n_mis = 0;

    alu_seq #(.WIDTH(16), .SHIFT_BY_B(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .out_v     (out_v),
        .out_z     (out_z),
        .out_n     (out_n)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {V, C} from plain arithmetic on the whole shift amount
    function automatic logic [16:0] model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] c;
        logic        v;
        int          k, s;
        k = int'(b[3:0]);
        v = 1'b0;
        case (op)
            4'h0: begin c = a + b; s = int'($signed(a)) + int'($signed(b)); v = (s > 32767) || (s < -32768); end
            4'h1: begin c = a - b; s = int'($signed(a)) - int'($signed(b)); v = (s > 32767) || (s < -32768); end
            4'h2: c = a & b;
            4'h3: c = a | b;
            4'h4: c = ~(a & b);
            4'h5: c = ~(a | b);
            4'h6: c = a ^ b;
            4'h7: c = ~(a ^ b);
            4'h8: c = a;
            4'h9: c = ~a;
            4'hA: c = a >> k;
            4'hB: c = $signed(a) >>> k;
            4'hC: c = (k == 0) ? a : ((a >> k) | (a << (16 - k)));
            4'hD, 4'hE: c = a << k;
            default: c = (k == 0) ? a : ((a << k) | (a >> (16 - k)));
        endcase
        return {v, c};
    endfunction

    task automatic scramble();
        in_op    = 4'($urandom);
        in_a     = 16'($urandom);
        in_b     = 16'($urandom);
        in_valid = 1'($urandom);
    endtask

    task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input int hold);
        logic [16:0] m;
        int          lat, cyc;
        bit          busy_bad;
        m   = model(op, a, b);
        lat = (op >= 4'hA && b[3:0] != 4'h0) ? int'(b[3:0]) + 1 : 1;
        @(negedge clk);
        check_eq("ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; out_ready = 1'b0;
        @(negedge clk);
        cyc = 1;
        busy_bad = 1'b0;
        while (!out_valid && cyc <= 40) begin
            if (in_ready) busy_bad = 1'b1;
            scramble();
            out_ready = 1'($urandom);
            @(negedge clk);
            cyc++;
        end
        scramble();
        out_ready = 1'b0;
        check_eq("latency", 32'(cyc), 32'(lat));
        check_eq("busy_ready", 32'(busy_bad), 32'd0);
        check_eq("out_c", 32'(out_c), 32'(m[15:0]));
        check_eq("out_v", 32'(out_v), 32'(m[16]));
        check_eq("out_z", 32'(out_z), 32'(m[15:0] == 16'h0));
        check_eq("out_n", 32'(out_n), 32'(m[15]));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            scramble();
            in_valid = 1'b1;
        end
        check_eq("hold_c", 32'(out_c), 32'(m[15:0]));
        check_eq("hold_valid", 32'(out_valid), 32'd1);
        check_eq("hold_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        check_eq("drain_valid", 32'(out_valid), 32'd0);
        check_eq("drain_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        bit seen;
        reset = 1'b1; in_valid = 1'b0; in_op = 4'h0; in_a = 16'h0; in_b = 16'h0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_ready", 32'(in_ready), 32'd1);
        check_eq("rst_c", 32'(out_c), 32'd0);
        check_eq("rst_flags", 32'({out_v, out_z, out_n}), 32'd0);

        do_op(4'h0, 16'h7FFF, 16'h0001, 0);
        do_op(4'h1, 16'h8000, 16'h0001, 0);
        do_op(4'h1, 16'h0005, 16'h0005, 1);
        do_op(4'hB, 16'h8010, 16'h0004, 0);
        do_op(4'hF, 16'h8001, 16'h0011, 0);
        do_op(4'hD, 16'h1234, 16'h0010, 0);
        do_op(4'h6, 16'hFF00, 16'h0FF0, 3);

        // Abort a shift with reset in its third SHIFT cycle
        @(negedge clk);
        in_valid = 1'b1; in_op = 4'hA; in_a = 16'hFFFF; in_b = 16'h000A;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("abort_valid", 32'(out_valid), 32'd0);
        check_eq("abort_ready", 32'(in_ready), 32'd1);
        check_eq("abort_c", 32'(out_c), 32'd0);
        seen = 1'b0;
        out_ready = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        out_ready = 1'b0;
        check_eq("abort_no_result", 32'(seen), 32'd0);

        for (int t = 0; t < 80; t++) begin
            do_op(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
